fifo_reader: RTL and testbench

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_reader.sv | 61 ++++++
 tb/tb_fifo_reader.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fifo_reader.sv
// fifo_reader: drains a synchronous FIFO read port into a 2-entry skid buffer with a valid/ready output
// Ports: Clk, Clear_in (sync active-high clear); FifoData_in/FifoEmpty_in/FifoReadEn_out (FIFO read side);
//        Data_out/Valid_out/Ready_in (downstream handshake); WordCount_out (only with FIFO_READER_COUNT_EN).
// Build option: define FIFO_READER_COUNT_EN to add the wrapping accepted-word counter.
module fifo_reader #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                  Clk,
  input  logic                  Clear_in,
  input  logic [DATA_WIDTH-1:0] FifoData_in,
  input  logic                  FifoEmpty_in,
  output logic                  FifoReadEn_out,
  input  logic                  Ready_in,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  Valid_out
`ifdef FIFO_READER_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0] WordCount_out
`endif
);
  logic [DATA_WIDTH-1:0] hd_q, hd_d, tl_q, tl_d;
  logic [1:0] occ_q, occ_d, occ_after, level;
  logic pend_q, pend_d, pop;
  assign Data_out  = hd_q;
  assign Valid_out = occ_q != 2'd0;
  always_comb begin
    pop            = Valid_out & Ready_in;
    // words owned after this edge: buffered plus in flight, minus the one leaving
    level          = occ_q + {1'b0, pend_q} - {1'b0, pop};
    FifoReadEn_out = ~FifoEmpty_in & ~Clear_in & (level < 2'd2);
    pend_d         = FifoReadEn_out & ~FifoEmpty_in;
    occ_after      = occ_q - {1'b0, pop};
    // a capture lands in the first slot left free after the pop shifts the tail forward
    hd_d           = (pend_q && occ_after == 2'd0) ? FifoData_in : pop ? tl_q : hd_q;
    tl_d           = (pend_q && occ_after != 2'd0) ? FifoData_in : tl_q;
    occ_d          = occ_after + {1'b0, pend_q};
  end
  always_ff @(posedge Clk) begin
    if (Clear_in) begin
      hd_q   <= '0;
      tl_q   <= '0;
      occ_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      hd_q   <= hd_d;
      tl_q   <= tl_d;
      occ_q  <= occ_d;
      pend_q <= pend_d;
    end
  end
`ifdef FIFO_READER_COUNT_EN
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  assign WordCount_out = cnt_q;
  always_comb cnt_d = cnt_q + COUNT_WIDTH'(pop);
  always_ff @(posedge Clk) begin
    if (Clear_in) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`endif
endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: randomized and directed checks of fifo_reader against a queue-based model
module tb_fifo_reader;
  logic       Clk = 1'b0;
  logic       Clear_in = 1'b1;
  logic [7:0] FifoData_in = '0;
  logic       FifoEmpty_in = 1'b1;
  logic       FifoReadEn_out;
  logic       Ready_in = 1'b0;
  logic [7:0] Data_out;
  logic       Valid_out;
`ifdef FIFO_READER_COUNT_EN
  logic [3:0] WordCount_out;
`endif

  fifo_reader #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) dut (
    .Clk(Clk),
    .Clear_in(Clear_in),
    .FifoData_in(FifoData_in),
    .FifoEmpty_in(FifoEmpty_in),
    .FifoReadEn_out(FifoReadEn_out),
    .Ready_in(Ready_in),
    .Data_out(Data_out),
    .Valid_out(Valid_out)
`ifdef FIFO_READER_COUNT_EN
    ,
    .WordCount_out(WordCount_out)
`endif
  );

  always #5 Clk = ~Clk;

  int total = 0, bad = 0;
  logic [7:0] fifo[$], exp_q[$], xfer[$];
  bit gnt_prev = 0, prev_clr = 0;
  logic [7:0] last_word = '0;
  int cnt_m = 0, n_gnt = 0, cyc = 0;
  logic lg_valid[64], lg_rd[64];
  logic [7:0] lg_data[64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, check outputs mid-cycle against the model, then advance the model.
  task automatic cycle(input bit clr, input bit rdy, input bit stall);
    bit ev, ep, er, gnt, pop;
    Clear_in     = clr;
    Ready_in     = rdy;
    FifoEmpty_in = stall || fifo.size() == 0;
    FifoData_in  = gnt_prev ? last_word : 8'($urandom);
    #4;
    ev = (exp_q.size() - int'(gnt_prev)) > 0;
    ep = ev && rdy;
    er = !FifoEmpty_in && !clr && (exp_q.size() - int'(ep) < 2);
    chk("valid", Valid_out, ev);
    chk("rd_en", FifoReadEn_out, er);
    if (ev) chk("data", Data_out, exp_q[0]);
    if (prev_clr) chk("data_after_clear", Data_out, 0);
`ifdef FIFO_READER_COUNT_EN
    chk("count", WordCount_out, cnt_m % 16);
`endif
    gnt = FifoReadEn_out && !FifoEmpty_in;
    pop = Valid_out && Ready_in;
    if (cyc < 64) begin
      lg_valid[cyc] = Valid_out;
      lg_data[cyc]  = Data_out;
      lg_rd[cyc]    = FifoReadEn_out;
    end
    cyc++;
    if (gnt) n_gnt++;
    if (pop) xfer.push_back(Data_out);
    @(posedge Clk);
    #1;
    if (gnt) last_word = fifo.pop_front();
    if (clr) begin
      exp_q.delete();
      cnt_m    = 0;
      gnt_prev = 0;
    end else begin
      if (ep) begin
        void'(exp_q.pop_front());
        cnt_m++;
      end
      if (gnt) exp_q.push_back(last_word);
      gnt_prev = gnt;
    end
    prev_clr = clr;
  endtask

  task automatic restart();
    fifo.delete();
    cycle(1, 0, 0);
    cyc   = 0;
    n_gnt = 0;
    xfer.delete();
  endtask

  initial begin
    bit ev_lit[6] = '{0, 0, 1, 1, 1, 0};
    @(posedge Clk);
    #1;
    prev_clr = 1;
    cycle(1, 0, 0);
    chk("reset_valid", Valid_out, 0);
    chk("reset_data", Data_out, 0);

    // three words, downstream always ready
    restart();
    fifo = '{8'h11, 8'h22, 8'h33};
    repeat (7) cycle(0, 1, 0);
    for (int i = 0; i < 6; i++) chk("seq3_valid", lg_valid[i], ev_lit[i]);
    chk("seq3_d2", lg_data[2], 8'h11);
    chk("seq3_d3", lg_data[3], 8'h22);
    chk("seq3_d4", lg_data[4], 8'h33);
    chk("seq3_grants", n_gnt, 3);

    // backpressure fills the buffer, then full-rate drain
    restart();
    for (int i = 0; i < 8; i++) fifo.push_back(8'(8'h40 + i));
    repeat (6) cycle(0, 0, 0);
    chk("bp_grants", n_gnt, 2);
    chk("bp_valid", Valid_out, 1);
    for (int i = 2; i < 6; i++) chk("bp_hold", lg_data[i], 8'h40);
    repeat (8) cycle(0, 1, 0);
    chk("bp_xfers", xfer.size(), 8);
    for (int i = 0; i < 8 && i < xfer.size(); i++) chk("bp_order", xfer[i], 8'(8'h40 + i));

    // alternating ready
    restart();
    for (int i = 0; i < 10; i++) fifo.push_back(8'(8'h60 + i));
    for (int i = 0; i < 30; i++) cycle(0, i % 2 == 0, 0);
    chk("toggle_xfers", xfer.size(), 10);
    for (int i = 0; i < 10 && i < xfer.size(); i++) chk("toggle_order", xfer[i], 8'(8'h60 + i));

    // clear right after the grant of 0xA5
    restart();
    fifo = '{8'hA5};
    cycle(0, 1, 0);
    chk("a5_grant", n_gnt, 1);
    cycle(1, 1, 0);
    repeat (4) cycle(0, 1, 0);
    chk("a5_rd_during_clear", lg_rd[1], 0);
    for (int i = 2; i < 6; i++) chk("a5_valid_low", lg_valid[i], 0);
    for (int i = 0; i < 6; i++) chk("a5_never_out", lg_data[i] == 8'hA5, 0);

`ifdef FIFO_READER_COUNT_EN
    restart();
    for (int i = 0; i < 17; i++) fifo.push_back(8'(i));
    repeat (22) cycle(0, 1, 0);
    chk("count_wrap", WordCount_out, 1);
`endif

    // random traffic with stalls and occasional clears
    restart();
    for (int i = 0; i < 3000; i++) begin
      if (fifo.size() < 4 && $urandom_range(2) == 0) fifo.push_back(8'($urandom));
      cycle($urandom_range(99) == 0, $urandom_range(2) != 0, $urandom_range(4) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
